// File: rtl/el2_pkg.sv
// Shared types for the LSU DCCM read-modify-write sequencer.
// Holds the sequencer state encoding used by el2_lsu_dccm_rmw.
package el2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } el2_dccm_rmw_state_t;

endpackage

// File: rtl/el2_lsu_dccm_byte_merge.sv
// Per-lane byte merge: lane i takes the new byte when i_be[i], else the old.
// Ports: i_be (lane enables), i_new / i_old (words), o_data (merged word).
module el2_lsu_dccm_byte_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W/8-1:0] i_be,
    input  logic [DATA_W-1:0]   i_new,
    input  logic [DATA_W-1:0]   i_old,
    output logic [DATA_W-1:0]   o_data
);

    for (genvar g = 0; g < DATA_W/8; g++) begin : g_lane
        assign o_data[8*g +: 8] = i_be[g] ? i_new[8*g +: 8] : i_old[8*g +: 8];
    end

endmodule

// File: rtl/el2_lsu_dccm_rmw.sv
// LSU DCCM request sequencer: loads, full stores and sub-word stores done as
// read-modify-write. Ports: req_* handshake in, rsp_* load data out, busy,
// dccm_* memory enables/addresses/data (hi copies lo). Optional macro
// EL2_DCCM_RMW_FASTWR_EN issues full-word stores in the acceptance cycle.
module el2_lsu_dccm_rmw
    import el2_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                busy,
    output logic                dccm_wren,
    output logic                dccm_rden,
    output logic [ADDR_W-1:0]   dccm_wr_addr_lo,
    output logic [ADDR_W-1:0]   dccm_wr_addr_hi,
    output logic [ADDR_W-1:0]   dccm_rd_addr_lo,
    output logic [ADDR_W-1:0]   dccm_rd_addr_hi,
    output logic [DATA_W-1:0]   dccm_wr_data_lo,
    output logic [DATA_W-1:0]   dccm_wr_data_hi,
    input  logic [DATA_W-1:0]   dccm_rd_data_lo
);

    localparam int NB = DATA_W / 8;

    el2_dccm_rmw_state_t r_state;
    logic              r_ready;
    logic              r_rsp_valid;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [NB-1:0]     r_be;
    logic [DATA_W-1:0] r_wdata;

    logic              w_xfer;
    logic              w_full;
    logic              w_none;
    logic              w_fast;
    logic              w_to_rd;
    logic              w_to_wr;
    logic [ADDR_W-1:0] w_addr_in;
    logic [DATA_W-1:0] w_merged;

    // r_ready is only ever high in IDLE, so w_xfer implies IDLE.
    assign w_xfer    = req_valid & r_ready;
    assign w_full    = &req_be;
    assign w_none    = ~|req_be;
    assign w_addr_in = req_addr & ~ADDR_W'(3);

`ifdef EL2_DCCM_RMW_FASTWR_EN
    assign w_fast = w_xfer & req_write & w_full;
`else
    assign w_fast = 1'b0;
`endif

    // Loads and partial stores read first; be == 0 stores stay in IDLE.
    assign w_to_rd = w_xfer & (~req_write | (~w_full & ~w_none));
    assign w_to_wr = w_xfer & req_write & w_full & ~w_fast;

    el2_lsu_dccm_byte_merge #(
        .DATA_W (DATA_W)
    ) u_merge (
        .i_be   (r_be),
        .i_new  (r_wdata),
        .i_old  (dccm_rd_data_lo),
        .o_data (w_merged)
    );

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_state     <= IDLE;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_xfer) begin
                        r_write <= req_write;
                        r_addr  <= w_addr_in;
                        r_be    <= req_be;
                        r_wdata <= req_wdata;
                    end
                    if (w_to_rd) begin
                        r_state <= RD;
                        r_ready <= 1'b0;
                    end else if (w_to_wr) begin
                        r_state <= WR;
                        r_ready <= 1'b0;
                    end
                end
                RD: begin
                    if (r_write) begin
                        r_state <= CAP;
                    end else begin
                        r_state     <= IDLE;
                        r_ready     <= 1'b1;
                        r_rsp_valid <= 1'b1;
                    end
                end
                CAP: begin
                    // Read data for the RD cycle is valid now.
                    r_wdata <= w_merged;
                    r_state <= WR;
                end
                WR: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready       = r_ready;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_rdata       = dccm_rd_data_lo;
    assign busy            = (r_state != IDLE);
    assign dccm_rden       = (r_state == RD);
    assign dccm_wren       = (r_state == WR) | w_fast;
    assign dccm_rd_addr_lo = r_addr;
    assign dccm_rd_addr_hi = r_addr;
    assign dccm_wr_addr_lo = w_fast ? w_addr_in : r_addr;
    assign dccm_wr_addr_hi = dccm_wr_addr_lo;
    assign dccm_wr_data_lo = w_fast ? req_wdata : r_wdata;
    assign dccm_wr_data_hi = dccm_wr_data_lo;

endmodule

// File: tb/tb_el2_lsu_dccm_rmw.sv
// Directed bench for el2_lsu_dccm_rmw with a memory model and event
// scoreboard; honours EL2_DCCM_RMW_FASTWR_EN when defined.
module tb_el2_lsu_dccm_rmw;

`ifdef EL2_DCCM_RMW_FASTWR_EN
    localparam int WLAT = 0;
    localparam int FGAP = 1;
`else
    localparam int WLAT = 1;
    localparam int FGAP = 2;
`endif

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic [31:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        busy;
    logic        dccm_wren;
    logic        dccm_rden;
    logic [15:0] dccm_wr_addr_lo;
    logic [15:0] dccm_wr_addr_hi;
    logic [15:0] dccm_rd_addr_lo;
    logic [15:0] dccm_rd_addr_hi;
    logic [31:0] dccm_wr_data_lo;
    logic [31:0] dccm_wr_data_hi;
    logic [31:0] rd_data;

    logic [31:0] mem [0:1023];
    logic        ld_en;
    logic [9:0]  ld_idx;
    logic [31:0] ld_val;

    int  cyc = 0;
    int  vectors = 0;
    int  errs = 0;
    ev_t q_wr[$];
    ev_t q_rd[$];
    ev_t q_rsp[$];

    el2_lsu_dccm_rmw #(
        .ADDR_W (16),
        .DATA_W (32)
    ) dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_be          (req_be),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .busy            (busy),
        .dccm_wren       (dccm_wren),
        .dccm_rden       (dccm_rden),
        .dccm_wr_addr_lo (dccm_wr_addr_lo),
        .dccm_wr_addr_hi (dccm_wr_addr_hi),
        .dccm_rd_addr_lo (dccm_rd_addr_lo),
        .dccm_rd_addr_hi (dccm_rd_addr_hi),
        .dccm_wr_data_lo (dccm_wr_data_lo),
        .dccm_wr_data_hi (dccm_wr_data_hi),
        .dccm_rd_data_lo (rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data valid the cycle after rden.
    always @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_val;
        if (dccm_wren) mem[dccm_wr_addr_lo[11:2]] <= dccm_wr_data_lo;
        if (dccm_rden) rd_data <= mem[dccm_rd_addr_lo[11:2]];
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $display("FAIL %s: observed %0h, required %0h", tag, obs, exp);
            $error("%s miscompare", tag);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] n,
                                          input logic [31:0] o,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    // Scoreboard side: every memory access / response must be expected.
    always @(negedge clk) begin
        ev_t e;
        chk("wr_rd_excl", 64'(dccm_wren & dccm_rden), 64'd0);
        chk("hi_eq_lo", {dccm_wr_addr_hi, dccm_wr_data_hi, dccm_rd_addr_hi},
            {dccm_wr_addr_lo, dccm_wr_data_lo, dccm_rd_addr_lo});
        if (dccm_wren) begin
            chk("wr_expected", 64'(q_wr.size() != 0), 64'd1);
            if (q_wr.size() != 0) begin
                e = q_wr.pop_front();
                chk("wr_ev", {cyc[15:0], dccm_wr_addr_lo, dccm_wr_data_lo},
                    {e.cyc[15:0], e.addr, e.data});
            end
        end
        if (dccm_rden) begin
            chk("rd_expected", 64'(q_rd.size() != 0), 64'd1);
            if (q_rd.size() != 0) begin
                e = q_rd.pop_front();
                chk("rd_ev", 64'({cyc[15:0], dccm_rd_addr_lo}),
                    64'({e.cyc[15:0], e.addr}));
            end
        end
        if (rsp_valid) begin
            chk("rsp_expected", 64'(q_rsp.size() != 0), 64'd1);
            if (q_rsp.size() != 0) begin
                e = q_rsp.pop_front();
                chk("rsp_ev", 64'({cyc[15:0], rsp_rdata}),
                    64'({e.cyc[15:0], e.data}));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] v);
        ld_en  = 1'b1;
        ld_idx = a[11:2];
        ld_val = v;
        step();
        ld_en  = 1'b0;
    endtask

    task automatic send(input logic w, input logic [15:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] old, input bit hold,
                        output int t);
        int          n;
        logic [15:0] aa;
        n = 0;
        while (!req_ready && n < 40) begin
            step();
            n++;
        end
        chk("accept_ready", 64'(req_ready), 64'd1);
        t  = cyc;
        aa = a & 16'hFFFC;
        if (!w) begin
            q_rd.push_back('{t + 1, aa, 32'h0});
            q_rsp.push_back('{t + 2, 16'h0, old});
        end else if (be == 4'hF) begin
            q_wr.push_back('{t + WLAT, aa, wd});
        end else if (be != 4'h0) begin
            q_rd.push_back('{t + 1, aa, 32'h0});
            q_wr.push_back('{t + 3, aa, merge(wd, old, be)});
        end
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_be    = be;
        req_wdata = wd;
        step();
        if (!hold) req_valid = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t1, t2, t3, t4, t5, t6, t7, t8, tp;
        rst_l     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_be    = '0;
        req_wdata = '0;
        ld_en     = 1'b0;
        ld_idx    = '0;
        ld_val    = '0;
        step();
        preload(16'h0104, 32'hDEADBEEF);
        preload(16'h0300, 32'h11223344);
        preload(16'h0400, 32'hAAAAAAAA);
        preload(16'h0500, 32'h55667788);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_ctl", 64'({busy, dccm_wren, dccm_rden, rsp_valid}), 64'd0);
        chk("rst_regs", {dccm_wr_addr_lo, dccm_rd_addr_lo, dccm_wr_data_lo}, 64'd0);
        rst_l = 1'b1;
        step();
        chk("ready_after_rst", 64'(req_ready), 64'd1);

        // Load, then full store, then load of the stored word.
        send(1'b0, 16'h0104, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, t1);
        send(1'b1, 16'h0200, 4'hF, 32'h12345678, 32'h0, 1'b0, t2);
        chk("load_next_acc", 64'(t2 - t1), 64'd2);
        send(1'b0, 16'h0202, 4'h0, 32'h0, 32'h12345678, 1'b0, t3);
        chk("full_next_acc", 64'(t3 - t2), 64'(FGAP));

        // Partial store with req_valid held and fields churning while busy.
        send(1'b1, 16'h0300, 4'b0010, 32'h0000AB00, 32'h11223344, 1'b1, t4);
        chk("load2_next_acc", 64'(t4 - t3), 64'd2);
        for (int k = 0; k < 3; k++) begin
            req_addr  = 16'h0700 + 16'(4 * k);
            req_be    = 4'hF;
            req_write = k[0];
            req_wdata = $urandom;
            chk("busy_hold", 64'(busy), 64'd1);
            chk("ready_hold", 64'(req_ready), 64'd0);
            step();
        end
        req_valid = 1'b0;
        send(1'b0, 16'h0300, 4'h0, 32'h0, 32'h1122AB44, 1'b0, t5);
        chk("part_next_acc", 64'(t5 - t4), 64'd4);

        // be == 0 store: no access, accepted next cycle.
        send(1'b1, 16'h0500, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0, t6);
        chk("be0_ready", 64'({req_ready, busy}), 64'b10);
        send(1'b0, 16'h0500, 4'h0, 32'h0, 32'h55667788, 1'b0, t7);
        chk("be0_next_acc", 64'(t7 - t6), 64'd1);

        // Back-to-back full stores.
        tp = 0;
        for (int k = 0; k < 3; k++) begin
            send(1'b1, 16'h0600 + 16'(4 * k), 4'hF, 32'hC0DE0000 + k,
                 32'h0, 1'b0, t8);
            if (k != 0) chk("b2b_gap", 64'(t8 - tp), 64'(FGAP));
            tp = t8;
        end

        // Reset in the CAP cycle of a partial store abandons the write.
        send(1'b1, 16'h0400, 4'b0001, 32'h000000CC, 32'hAAAAAAAA, 1'b0, t8);
        void'(q_wr.pop_back());
        step();
        rst_l = 1'b0;
        chk("rst_mid_state", 64'({req_ready, busy}), 64'b01);
        step();
        chk("rst_mid_ctl", 64'({req_ready, busy, dccm_wren}), 64'd0);
        chk("rst_mid_regs", {dccm_wr_addr_lo, dccm_rd_addr_lo, dccm_wr_data_lo}, 64'd0);
        step();
        rst_l = 1'b1;
        chk("rst_mid_ready", 64'(req_ready), 64'd0);
        step();
        chk("rst_rel_ready", 64'(req_ready), 64'd1);
        send(1'b0, 16'h0400, 4'h0, 32'h0, 32'hAAAAAAAA, 1'b0, t8);

        for (int k = 0; k < 6; k++) step();
        chk("q_wr_empty", 64'(q_wr.size()), 64'd0);
        chk("q_rd_empty", 64'(q_rd.size()), 64'd0);
        chk("q_rsp_empty", 64'(q_rsp.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
